// File: rtl/fx3_slave_fifo_writer.sv
// fx3_slave_fifo_writer: skid FIFO feeding the FX3 GPIF-II synchronous slave-FIFO write port.
// Generates loader backpressure and commits short packets with PKTEND on idle timeout or flush.
module fx3_slave_fifo_writer #(
    parameter logic [1:0]  SOCKET       = 2'd0,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned PKT_BYTES    = 512,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic        fx3_clk,
    input  logic        fx3_rst,
    input  logic        inVld,
    input  logic [7:0]  inData,
    input  logic        flush,
    input  logic        fx3_wmark_n,
    output logic        readPause,
    output logic        fx3_slwr_n,
    output logic        fx3_pktend_n,
    output logic [7:0]  fx3_data,
    output logic [1:0]  fx3_addr,
    output logic        overflow,
    output logic [31:0] pktCnt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int unsigned TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PAUSE_LVL = CW'(FIFO_DEPTH - 3);
    localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_BYTES - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        STALL  = 2'd2,
        PKTEND = 2'd3
    } st_t;

    st_t st;
    st_t st_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [PW-1:0] pkt_byte;
    logic [TW-1:0] idle_cnt;
    logic          flush_req;

    logic empty_c;
    logic full_c;
    logic pending_c;
    logic do_write_c;
    logic commit_c;
    logic push_c;
    logic drop_c;
    logic wrap_c;

    assign fx3_addr  = SOCKET;
    assign empty_c   = (count == CW'(0));
    assign full_c    = (count == DEPTH_C);
    assign pending_c = (pkt_byte != PW'(0));

    // A full FIFO still accepts a byte when the head is leaving in the same cycle.
    assign push_c = inVld && (!full_c || do_write_c);
    assign drop_c = inVld && full_c && !do_write_c;
    assign wrap_c = do_write_c && (pkt_byte == PKT_LAST);

    // Next-state and per-cycle bus actions.
    always_comb begin
        st_next    = st;
        do_write_c = 1'b0;
        commit_c   = 1'b0;
        case (st)
            IDLE: begin
                if (!empty_c && fx3_wmark_n) begin
                    st_next = WRITE;
                end else if (empty_c && pending_c &&
                             ((idle_cnt == IDLE_LAST) || flush_req)) begin
                    st_next = PKTEND;
                end
            end
            WRITE: begin
                if (!fx3_wmark_n) begin
                    st_next = STALL;
                end else if (empty_c) begin
                    st_next = IDLE;
                end else begin
                    do_write_c = 1'b1;
                end
            end
            STALL: begin
                if (fx3_wmark_n) begin
                    st_next = empty_c ? IDLE : WRITE;
                end
            end
            PKTEND: begin
                commit_c = 1'b1;
                st_next  = IDLE;
            end
            default: st_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push_c && !do_write_c) begin
            count_next = count + CW'(1);
        end else if (!push_c && do_write_c) begin
            count_next = count - CW'(1);
        end
    end

    // FIFO storage needs no reset; pointers and count define validity.
    always_ff @(posedge fx3_clk) begin
        if (push_c) begin
            mem[wr_ptr] <= inData;
        end
    end

    always_ff @(posedge fx3_clk) begin
        if (fx3_rst) begin
            st           <= IDLE;
            wr_ptr       <= AW'(0);
            rd_ptr       <= AW'(0);
            count        <= CW'(0);
            readPause    <= 1'b1;
            fx3_slwr_n   <= 1'b1;
            fx3_pktend_n <= 1'b1;
            fx3_data     <= 8'd0;
            overflow     <= 1'b0;
        end else begin
            st           <= st_next;
            count        <= count_next;
            readPause    <= (count_next >= PAUSE_LVL) || !fx3_wmark_n;
            fx3_slwr_n   <= !do_write_c;
            fx3_pktend_n <= !commit_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_write_c) begin
                rd_ptr   <= rd_ptr + AW'(1);
                fx3_data <= mem[rd_ptr];
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Packet accounting: FX3 auto-commits on wrap, PKTEND commits the partial remainder.
    always_ff @(posedge fx3_clk) begin
        if (fx3_rst) begin
            pkt_byte <= PW'(0);
            pktCnt   <= 32'd0;
        end else begin
            if (commit_c) begin
                pkt_byte <= PW'(0);
            end else if (do_write_c) begin
                pkt_byte <= pkt_byte + PW'(1);
            end
            if (commit_c || wrap_c) begin
                pktCnt <= pktCnt + 32'd1;
            end
        end
    end

    // A request left with nothing pending after the drain would only commit the next packet early.
    always_ff @(posedge fx3_clk) begin
        if (fx3_rst) begin
            flush_req <= 1'b0;
        end else if (commit_c) begin
            flush_req <= 1'b0;
        end else if (flush && pending_c && !wrap_c) begin
            flush_req <= 1'b1;
        end else if ((st == IDLE) && empty_c && !pending_c) begin
            flush_req <= 1'b0;
        end
    end

    always_ff @(posedge fx3_clk) begin
        if (fx3_rst) begin
            idle_cnt <= TW'(0);
        end else if ((st == IDLE) && empty_c && !inVld) begin
            if (idle_cnt != IDLE_LAST) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end else begin
            idle_cnt <= TW'(0);
        end
    end

endmodule

// File: tb/tb_fx3_slave_fifo_writer.sv
// Scoreboard bench for fx3_slave_fifo_writer: loader model pushes expected bytes,
// a negedge monitor pops and checks every write strobe and PKTEND pulse.
`timescale 1ns/1ps
module tb_fx3_slave_fifo_writer;

    localparam int unsigned T = 1024;

    logic        fx3_clk = 1'b0;
    logic        fx3_rst;
    logic        inVld;
    logic [7:0]  inData;
    logic        flush;
    logic        fx3_wmark_n;
    logic        readPause;
    logic        fx3_slwr_n;
    logic        fx3_pktend_n;
    logic [7:0]  fx3_data;
    logic [1:0]  fx3_addr;
    logic        overflow;
    logic [31:0] pktCnt;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       wm_at_edge = 1'b1;
    logic [7:0] exp_q[$];
    int         pe_q[$];
    int         first_in_cyc = -1;
    int         first_strobe_cyc = -1;
    int         last_strobe_cyc = -1;
    bit         pend_prev = 1'b0;
    bit         chk_pause = 1'b0;
    int         pause_seen = 0;

    fx3_slave_fifo_writer #(
        .SOCKET      (2'd0),
        .FIFO_DEPTH  (8),
        .PKT_BYTES   (512),
        .IDLE_TIMEOUT(T)
    ) dut (
        .fx3_clk     (fx3_clk),
        .fx3_rst     (fx3_rst),
        .inVld       (inVld),
        .inData      (inData),
        .flush       (flush),
        .fx3_wmark_n (fx3_wmark_n),
        .readPause   (readPause),
        .fx3_slwr_n  (fx3_slwr_n),
        .fx3_pktend_n(fx3_pktend_n),
        .fx3_data    (fx3_data),
        .fx3_addr    (fx3_addr),
        .overflow    (overflow),
        .pktCnt      (pktCnt)
    );

    always #5 fx3_clk = ~fx3_clk;

    // Edge counter and the watermark value the DUT sampled at each edge.
    always @(posedge fx3_clk) begin
        cyc        <= cyc + 1;
        wm_at_edge <= fx3_wmark_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic do_reset();
        fx3_rst     = 1'b1;
        inVld       = 1'b0;
        flush       = 1'b0;
        fx3_wmark_n = 1'b1;
        repeat (2) @(posedge fx3_clk);
        #1;
        exp_q.delete();
        pe_q.delete();
        first_in_cyc     = -1;
        first_strobe_cyc = -1;
        last_strobe_cyc  = -1;
        fx3_rst = 1'b0;
        @(posedge fx3_clk);
        #1;
    endtask

    // Loader model; when honoring, it reacts to readPause one cycle late (its own output register).
    task automatic send(input int n, input int start, input bit honor);
        int sent = 0;
        int iter = 0;
        bit pprev;
        bit p;
        pprev = readPause;
        while (sent < n && iter < n + 2000) begin
            p     = pprev;
            pprev = readPause;
            if (honor && p) begin
                inVld = 1'b0;
            end else begin
                inVld  = 1'b1;
                inData = 8'(start + sent);
                exp_q.push_back(inData);
                if (first_in_cyc < 0) first_in_cyc = cyc;
                sent++;
            end
            iter++;
            @(posedge fx3_clk);
            #1;
        end
        inVld = 1'b0;
        check("send_complete", 32'(sent), 32'(n));
    endtask

    task automatic wait_drain(input string name, input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(posedge fx3_clk);
            #1;
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_pktend(input int bound);
        int k = 0;
        while (pe_q.size() == 0 && k < bound) begin
            @(posedge fx3_clk);
            #1;
            k++;
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge fx3_clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge fx3_clk);
                if (!fx3_slwr_n) begin
                    check("strobe_under_wmark", 32'(wm_at_edge), 32'd1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: got data %0h, required no strobe (cycle %0d)",
                                 fx3_data, cyc);
                    end else begin
                        check("strobe_data", 32'(fx3_data), 32'(exp_q.pop_front()));
                    end
                    if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                    last_strobe_cyc = cyc;
                end
                if (!fx3_pktend_n) begin
                    pe_q.push_back(cyc);
                    check("pktend_without_slwr", 32'(fx3_slwr_n), 32'd1);
                    check("pktend_single_cycle", 32'(pend_prev), 32'd0);
                end
                pend_prev = !fx3_pktend_n;
                if (chk_pause && readPause) pause_seen++;
            end
        join_none

        // Reset values, then readPause release one edge after reset deasserts.
        fx3_rst     = 1'b1;
        inVld       = 1'b0;
        inData      = 8'd0;
        flush       = 1'b0;
        fx3_wmark_n = 1'b1;
        repeat (2) @(posedge fx3_clk);
        #1;
        check("rst_slwr_n",   32'(fx3_slwr_n),   32'd1);
        check("rst_pktend_n", 32'(fx3_pktend_n), 32'd1);
        check("rst_data",     32'(fx3_data),     32'd0);
        check("rst_readpause",32'(readPause),    32'd1);
        check("rst_overflow", 32'(overflow),     32'd0);
        check("rst_pktcnt",   pktCnt,            32'd0);
        check("addr_socket",  32'(fx3_addr),     32'd0);
        fx3_rst = 1'b0;
        @(posedge fx3_clk);
        #1;
        check("readpause_release", 32'(readPause), 32'd0);

        // Stream, no stall: 1024 bytes, two auto-committed packets.
        do_reset();
        chk_pause = 1'b1;
        send(1024, 0, 1'b1);
        wait_drain("stream_drain", 100);
        chk_pause = 1'b0;
        check("stream_no_pause", 32'(pause_seen), 32'd0);
        // Byte driven after edge n is pushed at n+1; strobe registered at n+3.
        check("stream_first_latency", 32'(first_strobe_cyc), 32'(first_in_cyc + 3));
        check("stream_pktcnt", pktCnt, 32'd2);
        check("stream_no_pktend", 32'(pe_q.size()), 32'd0);

        // Watermark stall for 20 cycles mid-stream.
        do_reset();
        fork
            send(60, 8'h30, 1'b1);
            begin
                repeat (20) @(posedge fx3_clk);
                #1;
                fx3_wmark_n = 1'b0;
                @(posedge fx3_clk);
                @(negedge fx3_clk);
                check("stall_readpause", 32'(readPause), 32'd1);
                repeat (19) @(posedge fx3_clk);
                #1;
                fx3_wmark_n = 1'b1;
            end
        join
        wait_drain("stall_drain", 100);
        check("stall_overflow", 32'(overflow), 32'd0);
        check("stall_pktcnt", pktCnt, 32'd0);

        // Idle short packet: PKTEND T+2 edges after the last write (T after first IDLE-empty edge).
        do_reset();
        send(100, 7, 1'b1);
        wait_drain("idle_drain", 50);
        wait_pktend(T + 50);
        check("idle_pktend_count", 32'(pe_q.size()), 32'd1);
        check("idle_pktend_cycle", 32'((pe_q.size() > 0) ? pe_q[0] : -1), 32'(last_strobe_cyc + T + 2));
        check("idle_pktcnt", pktCnt, 32'd1);

        // Flush with 5 bytes still queued behind a low watermark.
        do_reset();
        send(32, 8'h40, 1'b1);
        wait_drain("flush_drain_a", 50);
        fx3_wmark_n = 1'b0;
        send(5, 8'h60, 1'b0);
        pulse_flush();
        check("flush_queued", 32'(exp_q.size()), 32'd5);
        fx3_wmark_n = 1'b1;
        wait_drain("flush_drain_b", 50);
        wait_pktend(20);
        check("flush_pktend_count", 32'(pe_q.size()), 32'd1);
        // Last write at w; WRITE->IDLE at w+1; IDLE->PKTEND at w+2; strobe at w+3.
        check("flush_pktend_cycle", 32'((pe_q.size() > 0) ? pe_q[0] : -1), 32'(last_strobe_cyc + 3));
        check("flush_pktcnt", pktCnt, 32'd1);
        pulse_flush();
        repeat (30) @(posedge fx3_clk);
        #1;
        check("flush_second_ignored", 32'(pe_q.size()), 32'd1);
        check("flush_second_pktcnt", pktCnt, 32'd1);

        // Exact full packet then flush: zero-length packet suppressed.
        do_reset();
        send(512, 0, 1'b1);
        wait_drain("full_drain", 50);
        pulse_flush();
        repeat (40) @(posedge fx3_clk);
        #1;
        check("full_no_pktend", 32'(pe_q.size()), 32'd0);
        check("full_pktcnt", pktCnt, 32'd1);

        // Overflow with loader ignoring readPause and FX3 blocking writes.
        fx3_wmark_n = 1'b0;
        @(posedge fx3_clk);
        #1;
        inVld  = 1'b1;
        inData = 8'hA0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge fx3_clk);
            #1;
            check("overflow_after_byte", 32'(overflow), (i >= 9) ? 32'd1 : 32'd0);
            inData = 8'(8'hA0 + i);
        end

        // One-cycle reset mid-stream.
        fx3_rst = 1'b1;
        @(posedge fx3_clk);
        #1;
        check("mid_rst_slwr_n",    32'(fx3_slwr_n),   32'd1);
        check("mid_rst_pktend_n",  32'(fx3_pktend_n), 32'd1);
        check("mid_rst_data",      32'(fx3_data),     32'd0);
        check("mid_rst_readpause", 32'(readPause),    32'd1);
        check("mid_rst_overflow",  32'(overflow),     32'd0);
        check("mid_rst_pktcnt",    pktCnt,            32'd0);
        fx3_rst     = 1'b0;
        inVld       = 1'b0;
        fx3_wmark_n = 1'b1;
        repeat (20) @(posedge fx3_clk);
        #1;
        check("post_rst_no_pktend", 32'(pe_q.size()), 32'd0);
        check("post_rst_overflow",  32'(overflow),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fx3_slave_fifo_writer.md
# fx3_slave_fifo_writer

Downstream stage of the FX3 byte loader, in the `fx3_clk` domain. It takes the loader's registered byte stream (`outVld`/`dataOut`) and drives the FX3 GPIF-II synchronous slave-FIFO write interface. It generates the loader's `readPause` backpressure from its own skid-FIFO level and the FX3 watermark flag. It commits short packets with PKTEND on an idle timeout or on an explicit flush.

## Interface
- `SOCKET`, 2'd0: value driven on `fx3_addr` (FX3 producer socket).
- `FIFO_DEPTH`, 8: skid FIFO depth in bytes; power of 2, ≥ 8.
- `PKT_BYTES`, 512: FX3 DMA buffer size in bytes; power of 2.
- `IDLE_TIMEOUT`, 1024: idle cycles before a partial packet is committed; ≥ 4.

Ports:
- `fx3_clk`  in  1  clock.
- `fx3_rst`  in  1  reset; synchronous, active-high.
- `inVld`  in  1  byte valid from the loader.
- `inData`  in  8  byte from the loader.
- `flush`  in  1  single-cycle pulse requesting a commit of the partial packet once the FIFO drains.
- `fx3_wmark_n`  in  1  FX3 FLAGB; low means the FX3 buffer is within its watermark, stop writing.
- `readPause`  out  1  registered backpressure to the loader.
- `fx3_slwr_n`  out  1  slave-FIFO write strobe, active-low, registered.
- `fx3_pktend_n`  out  1  packet-end strobe, active-low, registered.
- `fx3_data`  out  8  slave-FIFO data, registered.
- `fx3_addr`  out  2  constant `SOCKET`.
- `overflow`  out  1  sticky flag; set when a byte arrives while the FIFO is full.
- `pktCnt`  out  32  count of committed packets, full and short.

## Operation

**Skid FIFO**
- `FIFO_DEPTH` bytes; `count` is 0..`FIFO_DEPTH`.
- Push on `inVld`; pop on each bus write.
- Push and pop in the same cycle leave `count` unchanged.
- Push while full with no pop: the byte is dropped and `overflow` is set. `overflow` clears only on reset.

**Backpressure**
- `readPause` is registered: `readPause <= (count_next >= FIFO_DEPTH-3) | ~fx3_wmark_n`.
- The loader's own 1-cycle register adds latency. The margin of 3 absorbs the worst case of 2 bytes in flight plus the same-cycle byte.

**State machine (`st`)**
- IDLE:
  - FIFO non-empty and `fx3_wmark_n`=1 → WRITE.
  - `pending` and (idle counter = `IDLE_TIMEOUT`-1 or `flushReq`) → PKTEND.
- WRITE:
  - Each cycle with FIFO non-empty and `fx3_wmark_n`=1: `fx3_slwr_n`=0, `fx3_data`=head, pop.
  - FIFO empty → IDLE.
  - `fx3_wmark_n`=0 → STALL.
- STALL:
  - `fx3_slwr_n`=1.
  - `fx3_wmark_n`=1 → WRITE if the FIFO is non-empty, else IDLE.
- PKTEND:
  - Exactly one cycle with `fx3_pktend_n`=0 and `fx3_slwr_n`=1.
  - Clears `pktByte` and `flushReq`; increments `pktCnt`.
  - → IDLE.

**Packet accounting**
- `pktByte` is a log2(`PKT_BYTES`)-bit counter, incremented per bus write.
- On wrap from `PKT_BYTES`-1 to 0 the FX3 auto-commits: `pktCnt`+1, no PKTEND.
- `pending` = (`pktByte` != 0).
- Zero-length packets are never sent.
  - A `flush` with `pending`=0 is ignored.
  - A `flush` that coincides with the full-packet wrap is ignored.

**Idle counter**
- Counts cycles in IDLE with FIFO empty and `inVld`=0.
- Clears on any `inVld`, on any write, and on leaving IDLE.
- Saturates at `IDLE_TIMEOUT`-1.

**Flush**
- `flush` sets a sticky `flushReq`.
- PKTEND is taken only from IDLE with the FIFO empty, so every queued byte is written first.
- `inVld` in the same cycle as the IDLE→PKTEND decision: PKTEND still occurs; the byte is queued and belongs to the next packet.

**Reset (mid-operation)**
- Discards FIFO contents and all counters; `st`=IDLE.
- No PKTEND is emitted for a partial packet.

## Timing
- Reset values:
  - `fx3_slwr_n`=1, `fx3_pktend_n`=1, `fx3_data`=0.
  - `readPause`=1 (released the first cycle after reset deasserts, when `fx3_wmark_n`=1).
  - `overflow`=0, `pktCnt`=0, `st`=IDLE.
- Latency:
  - `inVld` at cycle t → earliest `fx3_slwr_n`=0 with that byte at t+2 (push at t; IDLE→WRITE decision at t+1; registered strobe at t+2).
  - Sustained throughput is 1 byte/cycle while `fx3_wmark_n`=1.
- `fx3_wmark_n` sampled low at t → no write strobe at t+1 or later until it is sampled high again.
- `readPause` responds one cycle after `count` or `fx3_wmark_n` changes.
- `fx3_pktend_n` low for exactly one cycle, never concurrent with `fx3_slwr_n` low.
- `fx3_data` holds its last value when `fx3_slwr_n`=1.

## Test plan
- **Stream, no stall.**
  - Stimulus: 1024 bytes 0x00..0xFF repeating, `fx3_wmark_n`=1.
  - Required: 1024 strobes in order, first strobe 2 cycles after first `inVld`; `pktCnt`=2; no PKTEND; `readPause` never 1 after reset release.
- **Watermark stall.**
  - Stimulus: drop `fx3_wmark_n` for 20 cycles mid-stream, with the loader model honoring its 1-cycle `readPause` latency.
  - Required: no strobe from the cycle after the drop; `readPause`=1 within 1 cycle; no byte lost or duplicated; `overflow`=0.
- **Idle short packet.**
  - Stimulus: 100 bytes, then silence.
  - Required: `fx3_pktend_n` low for 1 cycle exactly `IDLE_TIMEOUT` cycles after the last byte enters IDLE-empty; `pktCnt`=1; `pktByte`=0.
- **Flush.**
  - Stimulus: 37 bytes then a `flush` pulse while 5 are still queued.
  - Required: all 37 written, then PKTEND on the cycle after the FIFO empties; a second `flush` with `pending`=0 produces no PKTEND.
- **Exact full packet + flush.**
  - Stimulus: 512 bytes, then `flush`.
  - Required: `pktCnt`=1, no PKTEND (zero-length suppressed).
- **Overflow / reset.**
  - Stimulus: loader model ignoring `readPause`, with `fx3_wmark_n`=0.
  - Required: `overflow`=1 after the 9th byte. Then `fx3_rst` for 1 cycle mid-stream: all outputs return to reset values on the next edge, and `overflow`=0.
